// File: rtl/eager_fork_dataless.sv
`default_nettype none
// ============================================================================
// Module      : eager_fork_dataless
// Description : Dataless eager fork. One input handshake token is copied onto
//               SIZE output channels, and each output may take its copy in a
//               different cycle. A pending flag per output records which
//               copies are still owed. The input is acknowledged in the cycle
//               the last owed copy is taken.
//               Optional macro EAGER_FORK_TOKEN_CNT_EN adds a free-running
//               32-bit count of input transfers on port token_count.
// Revision    : 1.0 - initial release
// ============================================================================
module eager_fork_dataless #(
    parameter int SIZE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ins_valid,
    output logic            ins_ready,
    output logic [SIZE-1:0] outs_valid,
    input  logic [SIZE-1:0] outs_ready
`ifdef EAGER_FORK_TOKEN_CNT_EN
    ,
    output logic [31:0]     token_count
`endif
);

    // All copies owed: the state for a fresh token and the reset state.
    localparam logic [SIZE-1:0] c_ALL_PENDING = {SIZE{1'b1}};

    logic [SIZE-1:0] r_pending;
    logic [SIZE-1:0] w_block;
    logic [SIZE-1:0] w_pending_next;
    logic            w_stall;
    logic            w_in_xfer;

    // Per output: a copy is offered only while still owed. An owed copy that
    // its consumer refuses blocks completion of the token. A copy already
    // taken neither offers nor blocks, so its ready input is ignored.
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
            assign outs_valid[gi] = ins_valid & r_pending[gi];
            assign w_block[gi]    = r_pending[gi] & ~outs_ready[gi];
        end
    endgenerate

    // The token completes once no owed copy is blocked. This is also true in
    // the cycle the last owed copy is taken, so tokens can go back to back.
    assign w_stall   = |w_block;
    assign ins_ready = ~w_stall;
    assign w_in_xfer = ins_valid & ~w_stall;

    // Next pending set: rearm on completion, otherwise keep only the copies
    // that were not taken this cycle. Without a token nothing changes.
    always_comb begin
        w_pending_next = r_pending;
        if (w_in_xfer) begin
            w_pending_next = c_ALL_PENDING;
        end else if (ins_valid) begin
            w_pending_next = w_block;
        end
    end

    // Pending register. Reset forgets any partly delivered token.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= c_ALL_PENDING;
        end else begin
            r_pending <= w_pending_next;
        end
    end

`ifdef EAGER_FORK_TOKEN_CNT_EN
    logic [31:0] r_token_count;

    // Count completed input transfers. The count wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_token_count <= 32'd0;
        end else if (w_in_xfer) begin
            r_token_count <= r_token_count + 32'd1;
        end
    end

    assign token_count = r_token_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eager_fork_dataless.sv
`default_nettype none
// ============================================================================
// Module      : tb_eager_fork_dataless
// Description : Self-checking bench for eager_fork_dataless (SIZE=3 and
//               SIZE=1 instances) against a delivered-copy reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eager_fork_dataless;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         ins_valid;
    logic         ins_ready;
    logic [N-1:0] outs_valid;
    logic [N-1:0] outs_ready;

    logic         s1_ins_valid;
    logic         s1_ins_ready;
    logic [0:0]   s1_outs_valid;
    logic [0:0]   s1_outs_ready;

`ifdef EAGER_FORK_TOKEN_CNT_EN
    logic [31:0]  token_count;
    logic [31:0]  s1_token_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: which copies of the current token have been handed out
    // and how many tokens have completed.
    bit          delivered [N];
    int unsigned tokens;

    eager_fork_dataless #(.SIZE(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
`ifdef EAGER_FORK_TOKEN_CNT_EN
        ,
        .token_count(token_count)
`endif
    );

    eager_fork_dataless #(.SIZE(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (s1_ins_valid),
        .ins_ready  (s1_ins_ready),
        .outs_valid (s1_outs_valid),
        .outs_ready (s1_outs_ready)
`ifdef EAGER_FORK_TOKEN_CNT_EN
        ,
        .token_count(s1_token_count)
`endif
    );

    always #5 clk = ~clk;

    // A copy is offered while a token is present and that copy is not yet out.
    function automatic logic [N-1:0] m_valid();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = ins_valid && !delivered[i];
        return r;
    endfunction

    // The token completes when every copy is either already out or taken now.
    function automatic logic m_ready();
        logic r;
        r = 1'b1;
        for (int i = 0; i < N; i++) if (!delivered[i] && !outs_ready[i]) r = 1'b0;
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < N; i++) delivered[i] = 1'b0;
        tokens = 0;
    endtask

    // Apply one clock edge to the model using the inputs held across it.
    task automatic m_clock();
        logic [N-1:0] v;
        v = m_valid();
        if (ins_valid) begin
            if (m_ready()) begin
                for (int i = 0; i < N; i++) delivered[i] = 1'b0;
                tokens++;
            end else begin
                for (int i = 0; i < N; i++) if (v[i] && outs_ready[i]) delivered[i] = 1'b1;
            end
        end
    endtask

    // Let the edge happen, update the model, return to the falling edge.
    task automatic tick();
        @(posedge clk);
        m_clock();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; ins_valid = 1'b1; outs_ready = 3'b000;
        s1_ins_valid = 1'b1; s1_outs_ready = 1'b0;
        m_reset();
        #1;
        vectors++;
        if (outs_valid !== 3'b111) begin
            miscompares++; $display("FAIL reset_outs_valid got %b want 111", outs_valid);
        end
        vectors++;
        if (ins_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_ins_ready got %b want 0", ins_ready);
        end
        outs_ready = 3'b111; #1;
        vectors++;
        if (ins_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_ins_ready_all got %b want 1", ins_ready);
        end
`ifdef EAGER_FORK_TOKEN_CNT_EN
        vectors++;
        if (token_count !== 32'd0) begin
            miscompares++; $display("FAIL reset_count got %0d want 0", token_count);
        end
`endif
        @(negedge clk);
        rst = 1'b0; outs_ready = 3'b000;
        #1;
        // Fresh token after reset: all copies offered.
        vectors++;
        if (outs_valid !== 3'b111) begin
            miscompares++; $display("FAIL post_reset_pending got %b want 111", outs_valid);
        end
        ins_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_broadcast();
        logic [31:0] start;
        start = tokens;
        ins_valid = 1'b1; outs_ready = 3'b111;
        for (int c = 0; c < 4; c++) begin
            #1;
            vectors++;
            if (ins_ready !== 1'b1 || outs_valid !== 3'b111) begin
                miscompares++;
                $display("FAIL broadcast_c%0d got rdy=%b vld=%b want rdy=1 vld=111", c, ins_ready, outs_valid);
            end
            tick();
        end
        vectors++;
        if (tokens - start != 4) begin
            miscompares++; $display("FAIL broadcast_tokens got %0d want 4", tokens - start);
        end
`ifdef EAGER_FORK_TOKEN_CNT_EN
        vectors++;
        if (token_count !== 32'(tokens)) begin
            miscompares++; $display("FAIL broadcast_count got %0d want %0d", token_count, tokens);
        end
`endif
        ins_valid = 1'b0; outs_ready = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_staggered();
        logic [N-1:0] rdy_tab [4];
        logic [N-1:0] vld_tab [4];
        logic         ir_tab  [4];
        rdy_tab = '{3'b001, 3'b100, 3'b010, 3'b000};
        vld_tab = '{3'b111, 3'b110, 3'b010, 3'b111};
        ir_tab  = '{1'b0,   1'b0,   1'b1,   1'b0};
        ins_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            outs_ready = rdy_tab[c];
            #1;
            vectors++;
            if (outs_valid !== vld_tab[c] || ins_ready !== ir_tab[c]) begin
                miscompares++;
                $display("FAIL staggered_c%0d got vld=%b rdy=%b want vld=%b rdy=%b",
                         c, outs_valid, ins_ready, vld_tab[c], ir_tab[c]);
            end
            tick();
        end
        // Finish the open token so later tests start clean.
        outs_ready = 3'b111; tick();
        ins_valid = 1'b0; outs_ready = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_no_duplicate();
        ins_valid = 1'b1; outs_ready = 3'b001;
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (outs_valid !== 3'b110 || ins_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL no_dup_c%0d got vld=%b rdy=%b want vld=110 rdy=0", c, outs_valid, ins_ready);
            end
            tick();
        end
        outs_ready = 3'b110; #1;
        vectors++;
        if (ins_ready !== 1'b1) begin
            miscompares++; $display("FAIL no_dup_finish got %b want 1", ins_ready);
        end
        tick();
        ins_valid = 1'b0; outs_ready = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        ins_valid = 1'b1; outs_ready = 3'b011;
        tick();
        outs_ready = 3'b000; #1;
        vectors++;
        if (outs_valid !== 3'b100) begin
            miscompares++; $display("FAIL areset_pre got %b want 100", outs_valid);
        end
        #1 rst = 1'b1;
        m_reset();
        #1;
        vectors++;
        if (outs_valid !== 3'b111) begin
            miscompares++; $display("FAIL areset_valid got %b want 111", outs_valid);
        end
`ifdef EAGER_FORK_TOKEN_CNT_EN
        vectors++;
        if (token_count !== 32'd0) begin
            miscompares++; $display("FAIL areset_count got %0d want 0", token_count);
        end
`endif
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (outs_valid !== 3'b111) begin
            miscompares++; $display("FAIL areset_after got %b want 111", outs_valid);
        end
        outs_ready = 3'b111; tick();
        ins_valid = 1'b0; outs_ready = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [N-1:0] ev;
        logic         er;
        for (int c = 0; c < 300; c++) begin
            ins_valid  = ($urandom_range(0, 9) < 8);
            outs_ready = N'($urandom);
            #1;
            ev = m_valid();
            er = m_ready();
            vectors++;
            if (outs_valid !== ev || ins_ready !== er) begin
                miscompares++;
                $display("FAIL random_c%0d got vld=%b rdy=%b want vld=%b rdy=%b", c, outs_valid, ins_ready, ev, er);
            end
            tick();
`ifdef EAGER_FORK_TOKEN_CNT_EN
            vectors++;
            if (token_count !== 32'(tokens)) begin
                miscompares++; $display("FAIL random_count_c%0d got %0d want %0d", c, token_count, tokens);
            end
`endif
        end
        ins_valid = 1'b0; outs_ready = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_size1();
        s1_ins_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            s1_outs_ready = 1'($urandom);
            #1;
            vectors++;
            if (s1_ins_ready !== s1_outs_ready[0] || s1_outs_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL size1_c%0d got rdy=%b vld=%b want rdy=%b vld=1", c, s1_ins_ready, s1_outs_valid, s1_outs_ready[0]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_staggered();
        test_no_duplicate();
        test_async_reset();
        test_random();
        test_size1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eager_fork_dataless.md
Name: eager_fork_dataless

Overview:
- Dataless eager fork: replicates one input handshake token onto SIZE output channels. This is the counterpart of the dataless merge, which funnels N channels into one.
- Each output may accept its copy in a different cycle.
- Per-output "pending" flags track which copies are still owed.
- The input is acknowledged only in the cycle the last outstanding copy is taken.
- Used in control-flow (token-only) networks wherever one control token must feed several consumers.

Parameters:
- SIZE, 2, number of output channels (>= 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ins_valid  input  1  input token present.
- ins_ready  output  1  input token consumed this cycle.
- outs_valid  output  SIZE  per-output token present.
- outs_ready  input  SIZE  per-output consumer accepts.

Behaviour:
- State: pending[SIZE-1:0].
  - pending[i]=1 means copy i of the current token has not yet been transferred.
  - Async reset sets pending to all ones. No other state.
- Combinational outputs:
  - outs_valid[i] = ins_valid & pending[i]. Zero latency from input to outputs.
  - block[i] = pending[i] & ~outs_ready[i].
  - stall = OR(block).
  - ins_ready = ~stall.
- Transfers:
  - Output i transfers when outs_valid[i] & outs_ready[i].
  - The input transfers when ins_valid & ins_ready.
- Next state for every i:
  - If ins_valid & ~stall: pending <= all ones. The token is complete; rearm for the next token.
  - Else if ins_valid: pending[i] <= block[i]. Copies taken this cycle are cleared; the others stay owed.
  - Else: pending unchanged.
- Reset values while rst is asserted:
  - pending = all ones.
  - outs_valid = {SIZE{ins_valid}}; combinational, so each output follows ins_valid.
  - ins_ready = AND(outs_ready).
- Boundary conditions:
  - All outputs ready in the same cycle: single-cycle transfer. ins_ready=1 and pending stays all ones.
  - Copy already taken (pending[i]=0):
    - outs_valid[i]=0 and outs_ready[i] is ignored.
    - Output i never receives a duplicate of the same token.
  - Last owed copy taken: ins_ready=1 in that same cycle. Back-to-back tokens are possible with no bubble.
  - ins_valid dropping while copies are owed:
    - Protocol violation; the producer must hold ins_valid until ins_ready.
    - The block keeps pending unchanged and does not recover the token.
  - Reset asserted mid-token: pending returns to all ones asynchronously. Partially delivered copies are forgotten.
  - SIZE=1: degenerates to a wire. outs_valid=ins_valid, ins_ready=outs_ready, and pending stays 1.
- No throughput limit: one token per cycle when all consumers are ready.

Optional Feature:
- Macro: EAGER_FORK_TOKEN_CNT_EN.
- When defined:
  - Adds output port token_count [31:0].
  - The counter increments by 1 on each input transfer (ins_valid & ins_ready) and wraps from 0xFFFFFFFF to 0.
  - Async reset clears it to 0.
  - It is registered: the value reflects transfers up to the previous edge.
- When undefined: no port, no counter logic. Handshake behaviour is identical in both cases.

Test Plan (SIZE=3 unless stated):
1. rst=1, ins_valid=1, outs_ready=3'b000:
   - outs_valid=3'b111, ins_ready=0.
   - After rst=0, pending=3'b111.
2. ins_valid=1 and outs_ready=3'b111 held for 4 cycles:
   - ins_ready=1 every cycle, 4 tokens transferred, pending stays 3'b111.
   - With EAGER_FORK_TOKEN_CNT_EN: token_count=4.
3. ins_valid=1; outs_ready=3'b001 in cycle 0, 3'b100 in cycle 1, 3'b010 in cycle 2:
   - outs_valid=111, then 110, then 010.
   - ins_ready=0, 0, then 1.
   - Cycle 3 shows outs_valid=111 for the next token.
4. After copy 0 is taken, outs_ready=3'b001 while the others stall:
   - outs_valid[0]=0, so no duplicate is delivered.
   - pending=3'b110 is held until the other outputs accept.
5. Mid-token, with pending=3'b100, pulse rst asynchronously between edges:
   - pending=3'b111 immediately and outs_valid=111 while ins_valid=1.
   - With EAGER_FORK_TOKEN_CNT_EN: token_count=0.
6. SIZE=1: toggle outs_ready randomly with ins_valid=1:
   - ins_ready equals outs_ready every cycle and outs_valid=1.
